// File: rtl/inert_pkg.sv
// Shared types and command words for the inertial sensor sequencer.
package inert_pkg;

  typedef enum logic [3:0] {
    PWRUP,
    CFG,
    CFG_WT,
    IDLE,
    RD_L,
    RD_L_WT,
    RD_H,
    RD_H_WT,
    RL_L,
    RL_L_WT,
    RL_H,
    RL_H_WT
  } state_t;

  localparam logic [15:0] CFG_INT  = 16'h0D02;
  localparam logic [15:0] CFG_ACC  = 16'h1053;
  localparam logic [15:0] CFG_GYR  = 16'h1150;
  localparam logic [15:0] CFG_RND  = 16'h1460;
  localparam logic [15:0] RD_PTCHL = 16'hA200;
  localparam logic [15:0] RD_PTCHH = 16'hA300;
  localparam logic [15:0] RD_ROLLL = 16'hA400;
  localparam logic [15:0] RD_ROLLH = 16'hA500;

  localparam int CFG_CNT = 4;

  function automatic logic [15:0] cfg_word(input logic [1:0] idx);
    case (idx)
      2'd0:    return CFG_INT;
      2'd1:    return CFG_ACC;
      2'd2:    return CFG_GYR;
      default: return CFG_RND;
    endcase
  endfunction

endpackage

// File: rtl/int_sync.sv
// Two-flop synchronizer bringing the sensor INT level into the clk domain.
module int_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic sync
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
    end
  end

endmodule

// File: rtl/inert_intf_ctrl.sv
// Sequencer driving the SPI monarch: power-up wait, config writes, then pitch reads on INT.
// Defining ROLL_RD_EN adds rollL/rollH reads and a roll output updated together with ptch.
module inert_intf_ctrl
  import inert_pkg::*;
#(
  parameter int INIT_TMR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               INT,
  input  logic               done,
  input  logic [15:0]        rd_data,
  output logic               wrt,
  output logic [15:0]        wt_data,
  output logic signed [15:0] ptch,
`ifdef ROLL_RD_EN
  output logic signed [15:0] roll,
`endif
  output logic               vld,
  output logic               init_done
);

  localparam logic [1:0] CFG_LAST = 2'(CFG_CNT - 1);

  state_t                state;
  state_t                nxt;
  logic [INIT_TMR_W-1:0] tmr;
  logic [1:0]            cfg_idx;
  logic                  int_s;

  logic                  issue;
  logic [15:0]           cmd;
  logic                  cfg_adv;
  logic                  cfg_fin;
  logic                  cap_pl;
  logic                  upd;
  logic [7:0]            ptch_l;
`ifdef ROLL_RD_EN
  logic                  cap_ph;
  logic                  cap_rl;
  logic [7:0]            ptch_h;
  logic [7:0]            roll_l;
`endif

  // Only the low byte of each read carries sensor data.
  logic rd_hi_unused;
  assign rd_hi_unused = ^rd_data[15:8];

  int_sync u_int_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (INT),
    .sync (int_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= PWRUP;
      tmr     <= '0;
      cfg_idx <= '0;
    end else begin
      state   <= nxt;
      tmr     <= (state == PWRUP) ? tmr + INIT_TMR_W'(1) : '0;
      if (cfg_adv) cfg_idx <= cfg_idx + 2'd1;
    end
  end

  // Issue states last one cycle; the matching *_WT state holds until done.
  always_comb begin
    nxt     = state;
    issue   = 1'b0;
    cmd     = '0;
    cfg_adv = 1'b0;
    cfg_fin = 1'b0;
    cap_pl  = 1'b0;
    upd     = 1'b0;
`ifdef ROLL_RD_EN
    cap_ph  = 1'b0;
    cap_rl  = 1'b0;
`endif
    case (state)
      PWRUP: if (&tmr) nxt = CFG;
      CFG: begin
        issue = 1'b1;
        cmd   = cfg_word(cfg_idx);
        nxt   = CFG_WT;
      end
      CFG_WT: if (done) begin
        cfg_adv = 1'b1;
        if (cfg_idx == CFG_LAST) begin
          cfg_fin = 1'b1;
          nxt     = IDLE;
        end else begin
          nxt = CFG;
        end
      end
      IDLE: if (int_s) nxt = RD_L;
      RD_L: begin
        issue = 1'b1;
        cmd   = RD_PTCHL;
        nxt   = RD_L_WT;
      end
      RD_L_WT: if (done) begin
        cap_pl = 1'b1;
        nxt    = RD_H;
      end
      RD_H: begin
        issue = 1'b1;
        cmd   = RD_PTCHH;
        nxt   = RD_H_WT;
      end
`ifdef ROLL_RD_EN
      RD_H_WT: if (done) begin
        cap_ph = 1'b1;
        nxt    = RL_L;
      end
      RL_L: begin
        issue = 1'b1;
        cmd   = RD_ROLLL;
        nxt   = RL_L_WT;
      end
      RL_L_WT: if (done) begin
        cap_rl = 1'b1;
        nxt    = RL_H;
      end
      RL_H: begin
        issue = 1'b1;
        cmd   = RD_ROLLH;
        nxt   = RL_H_WT;
      end
      RL_H_WT: if (done) begin
        upd = 1'b1;
        nxt = IDLE;
      end
`else
      RD_H_WT: if (done) begin
        upd = 1'b1;
        nxt = IDLE;
      end
`endif
      default: nxt = PWRUP;
    endcase
  end

  // Output register stage: wrt/wt_data launch, sample assembly, vld strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrt       <= 1'b0;
      wt_data   <= '0;
      init_done <= 1'b0;
      vld       <= 1'b0;
      ptch      <= '0;
      ptch_l    <= '0;
`ifdef ROLL_RD_EN
      ptch_h    <= '0;
      roll_l    <= '0;
      roll      <= '0;
`endif
    end else begin
      wrt <= issue;
      vld <= upd;
      if (issue)   wt_data   <= cmd;
      if (cfg_fin) init_done <= 1'b1;
      if (cap_pl)  ptch_l    <= rd_data[7:0];
`ifdef ROLL_RD_EN
      if (cap_ph)  ptch_h    <= rd_data[7:0];
      if (cap_rl)  roll_l    <= rd_data[7:0];
      if (upd) begin
        ptch <= $signed({ptch_h, ptch_l});
        roll <= $signed({rd_data[7:0], roll_l});
      end
`else
      if (upd) ptch <= $signed({rd_data[7:0], ptch_l});
`endif
    end
  end

endmodule

// File: tb/tb_inert_intf_ctrl.sv
// Directed bench for inert_intf_ctrl with a behavioural SPI/sensor responder.
// Define ROLL_RD_EN to exercise the roll-read build.
module tb_inert_intf_ctrl;

  localparam int TMR_W     = 8;
  localparam int PWRUP_CYC = 256;
`ifdef ROLL_RD_EN
  localparam int NRD = 4;
  localparam logic [6:0] LAST_ADDR = 7'h25;
`else
  localparam int NRD = 2;
  localparam logic [6:0] LAST_ADDR = 7'h23;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        INT = 1'b0;
  logic        done;
  logic        model_done = 1'b0;
  logic        spur_done = 1'b0;
  logic [15:0] rd_data = 16'h0000;
  logic        wrt;
  logic [15:0] wt_data;
  logic [15:0] ptch;
  logic        vld;
  logic        init_done;
`ifdef ROLL_RD_EN
  logic [15:0] roll;
`endif

  assign done = model_done | spur_done;

  int total = 0;
  int bad = 0;

  logic [15:0] cfg_exp  [0:3] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
  logic [15:0] rd_exp   [0:3] = '{16'hA200, 16'hA300, 16'hA400, 16'hA500};
  logic [15:0] ptch_tbl [0:4] = '{16'h5663, 16'hCD0D, 16'h8001, 16'h7FFE, 16'h0180};
  logic [15:0] roll_tbl [0:4] = '{16'h1234, 16'hABCD, 16'hFFFF, 16'h0102, 16'h8000};
  logic [15:0] rd_cmd   [0:7];
  logic [7:0]  regs     [0:127];

  inert_intf_ctrl #(.INIT_TMR_W(TMR_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .INT      (INT),
    .done     (done),
    .rd_data  (rd_data),
    .wrt      (wrt),
    .wt_data  (wt_data),
    .ptch     (ptch),
`ifdef ROLL_RD_EN
    .roll     (roll),
`endif
    .vld      (vld),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] sensor_byte(input logic [6:0] a, input int s);
    int k;
    logic [15:0] p;
    logic [15:0] r;
    k = (s > 4) ? 4 : s;
    p = ptch_tbl[k];
    r = roll_tbl[k];
    case (a)
      7'h22:   return p[7:0];
      7'h23:   return p[15:8];
      7'h24:   return r[7:0];
      7'h25:   return r[15:8];
      default: return 8'h00;
    endcase
  endfunction

  // SPI monarch + sensor responder; also watches wrt protocol on every launch.
  int          samp = 0;
  int          cnt = 0;
  logic        busy = 1'b0;
  logic        wrt_prev = 1'b0;
  logic [15:0] cur = 16'h0000;

  always begin
    @(posedge clk);
    #1;
    model_done = 1'b0;
    if (!rst_n) begin
      busy     = 1'b0;
      cnt      = 0;
      wrt_prev = 1'b0;
    end else begin
      if (wrt === 1'b1) begin
        check("wrt_while_busy", 32'(busy), 32'd0);
        check("wrt_width", 32'(wrt_prev), 32'd0);
        busy = 1'b1;
        cnt  = 4;
        cur  = wt_data;
      end else if (busy) begin
        cnt--;
        if (cnt == 0) begin
          busy       = 1'b0;
          model_done = 1'b1;
          if (!cur[15]) begin
            regs[cur[14:8]] = cur[7:0];
          end else begin
            rd_data = {8'hA5, sensor_byte(cur[14:8], samp)};
            if (cur[14:8] == LAST_ADDR) samp++;
          end
        end
      end
      wrt_prev = wrt;
    end
  end

  task automatic wait_wrt(input int budget, output logic [15:0] w, output int n, output logic f);
    n = 0;
    while (wrt !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    f = (wrt === 1'b1);
    w = wt_data;
    @(negedge clk);
  endtask

  task automatic init_seq(input string tag);
    int          seen;
    int          n;
    logic        f;
    logic [15:0] w;
    seen = 0;
    for (int i = 0; i < PWRUP_CYC; i++) begin
      @(negedge clk);
      if (wrt === 1'b1) seen++;
      if (i == 100) INT = 1'b0;
    end
    check({tag, "_pwrup_quiet"}, 32'(seen), 32'd0);
    check({tag, "_init_low"}, 32'(init_done), 32'd0);
    for (int i = 0; i < 4; i++) begin
      wait_wrt(20, w, n, f);
      if (i == 0) check({tag, "_first_wrt_cycle"}, 32'(n), 32'd1);
      check({tag, "_cfg_found"}, 32'(f), 32'd1);
      check({tag, "_cfg_word"}, 32'(w), 32'(cfg_exp[i]));
    end
    n = 0;
    while (init_done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_init_done"}, 32'(init_done), 32'd1);
  endtask

  task automatic collect(input logic drop_int, input logic [15:0] hold_val,
                         output int nrd, output logic hold_ok, output logic timely,
                         output logic got);
    int last_done;
    last_done = -10;
    nrd       = 0;
    hold_ok   = 1'b1;
    timely    = 1'b0;
    got       = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      if (vld === 1'b1) begin
        got    = 1'b1;
        timely = (last_done == c - 1);
      end else begin
        if (ptch !== hold_val) hold_ok = 1'b0;
        if (wrt === 1'b1) begin
          if (nrd < 8) rd_cmd[nrd] = wt_data;
          nrd++;
          if (drop_int) INT = 1'b0;
        end
        if (done === 1'b1) last_done = c;
      end
    end
  endtask

  task automatic do_sample(input string tag, input logic drop_int, input logic [15:0] hold_val,
                           input int first, input int exp_nrd, input int s);
    int   nrd;
    logic hold_ok;
    logic timely;
    logic got;
    collect(drop_int, hold_val, nrd, hold_ok, timely, got);
    check({tag, "_vld_seen"}, 32'(got), 32'd1);
    check({tag, "_vld_after_done"}, 32'(timely), 32'd1);
    check({tag, "_ptch_hold"}, 32'(hold_ok), 32'd1);
    check({tag, "_nreads"}, 32'(nrd), 32'(exp_nrd));
    for (int i = 0; i < exp_nrd && i < 8; i++)
      check({tag, "_rd_cmd"}, 32'(rd_cmd[i]), 32'(rd_exp[first + i]));
    check({tag, "_ptch"}, 32'(ptch), 32'(ptch_tbl[s]));
`ifdef ROLL_RD_EN
    check({tag, "_roll"}, 32'(roll), 32'(roll_tbl[s]));
`endif
    @(negedge clk);
    check({tag, "_vld_one_clk"}, 32'(vld), 32'd0);
  endtask

  initial begin
    logic [15:0] w;
    int          n;
    logic        f;
    int          seen;

    rst_n = 1'b0;
    INT   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wrt", 32'(wrt), 32'd0);
    check("rst_wt_data", 32'(wt_data), 32'd0);
    check("rst_ptch", 32'(ptch), 32'd0);
    check("rst_vld", 32'(vld), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
`ifdef ROLL_RD_EN
    check("rst_roll", 32'(roll), 32'd0);
`endif

    // INT high during power-up must not trigger a read
    INT   = 1'b1;
    rst_n = 1'b1;
    init_seq("boot");
    check("cfg_reg13", 32'(regs[7'h0D]), 32'h02);
    check("cfg_reg20", 32'(regs[7'h14]), 32'h60);

    // stray done with nothing outstanding
    seen = 0;
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (wrt === 1'b1 || vld === 1'b1) seen++;
    end
    check("spur_done_quiet", 32'(seen), 32'd0);
    check("spur_done_ptch", 32'(ptch), 32'd0);

    INT = 1'b1;
    do_sample("s1", 1'b1, 16'h0000, 0, NRD, 0);
    INT = 1'b1;
    do_sample("s2", 1'b1, ptch_tbl[0], 0, NRD, 1);

    // INT left high across the return to IDLE: read restarts at once
    INT = 1'b1;
    do_sample("s3", 1'b0, ptch_tbl[1], 0, NRD, 2);
    wait_wrt(6, w, n, f);
    INT = 1'b0;
    check("reread_found", 32'(f), 32'd1);
    check("reread_cmd", 32'(w), 32'hA200);
    do_sample("s4", 1'b1, ptch_tbl[2], 1, NRD - 1, 3);

    // reset in the middle of the pitchH transaction
    INT = 1'b1;
    f = 1'b0;
    for (int c = 0; c < 200 && !f; c++) begin
      @(negedge clk);
      if (wrt === 1'b1) begin
        INT = 1'b0;
        if (wt_data === 16'hA300) f = 1'b1;
      end
    end
    check("rdh_reached", 32'(f), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ptch", 32'(ptch), 32'd0);
    check("midrst_vld", 32'(vld), 32'd0);
    check("midrst_wrt", 32'(wrt), 32'd0);
    check("midrst_wt_data", 32'(wt_data), 32'd0);
    check("midrst_init_done", 32'(init_done), 32'd0);
    repeat (3) @(negedge clk);
    INT   = 1'b1;
    rst_n = 1'b1;
    init_seq("reboot");
    INT = 1'b1;
    do_sample("s5", 1'b1, 16'h0000, 0, NRD, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/inert_intf_ctrl.md
Name: inert_intf_ctrl

Overview:
- Sequencer that owns the SPI_mnrch monarch and drives all traffic to the iNEMO inertial sensor.
- After reset it waits for sensor power-up, then issues a fixed configuration-write sequence.
- It then waits on the sensor INT (data-ready), reads pitchL/pitchH, assembles a signed 16-bit pitch sample and pulses vld.
- Sits between SPI_mnrch and the balance/pitch-processing logic.

Parameters:
- INIT_TMR_W, 16, width of the power-up wait counter; the wait lasts 2^INIT_TMR_W clk cycles. Benches set 8 for fast simulation.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- INT  input  1  sensor data-ready; asynchronous to clk
- done  input  1  SPI_mnrch transaction complete (1-clk pulse)
- rd_data  input  16  SPI_mnrch read data; the low byte is valid when done is high
- wrt  output  1  1-clk pulse starting an SPI_mnrch transaction
- wt_data  output  16  SPI command word {R/W+addr, data}
- ptch  output  16  latest pitch sample {pitchH, pitchL}
- vld  output  1  1-clk pulse when ptch updates
- init_done  output  1  high once the configuration sequence completes

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low (clk, rst_n). All flops reset asynchronously on rst_n low.
- Reset values: wrt=0, wt_data=16'h0000, ptch=16'h0000, vld=0, init_done=0. The power-up counter clears, and the FSM returns to PWRUP.
- INT is double-flopped (two clk) before use. Only the synchronized level is used.
- States:
  - PWRUP: count each clk. At terminal count (all ones), go to CFG.
  - CFG: issue the configuration words in order 0x0D02, 0x1053, 0x1150, 0x1460.
  - IDLE: init_done=1. Wait for synchronized INT=1.
  - RD_L: read 0xA200 (pitchL).
  - RD_H: read 0xA300 (pitchH).
- Transaction rule for every command:
  - wt_data is driven with the word and wrt=1 for exactly one cycle.
  - wt_data holds until done.
  - The FSM waits in a WAIT sub-state for done.
  - The next wrt is asserted no earlier than the cycle after done.
  - wrt is never asserted while a transaction is outstanding.
- The config index increments on each done. After the 4th done, go to IDLE.
- RD_L: on done, capture rd_data[7:0] into a pitchL holding register, then go to RD_H.
- RD_H: on done, ptch <= {rd_data[7:0], pitchL_hold}. vld=1 in the following cycle only. Return to IDLE.
- Latency: ptch/vld update exactly one clk after the RD_H done.
- INT still high on return to IDLE (the sensor has not yet cleared it): start a new read immediately. This is the required behaviour; no edge detection.
- INT asserted during PWRUP/CFG is ignored.
- done arriving when no transaction is outstanding is ignored.
- rst_n low mid-transaction: outputs go to reset values immediately. The sequence restarts from PWRUP; configuration is rewritten.
- ptch holds its value between samples and is never partially updated.

Optional Feature:
- Macro: ROLL_RD_EN.
- When defined:
  - Adds output roll[15:0] (reset 0).
  - After RD_H, also reads 0xA400 (rollL) then 0xA500 (rollH).
  - ptch and roll update together. vld pulses once, one clk after the rollH done.
- When undefined: no roll port; behaviour is exactly as above.

Decomposition:
- Package inert_pkg holds:
  - the state enum
  - localparams for command words: CFG_INT=16'h0D02, CFG_ACC=16'h1053, CFG_GYR=16'h1150, CFG_RND=16'h1460, RD_PTCHL=16'hA200, RD_PTCHH=16'hA300, RD_ROLLL=16'hA400, RD_ROLLH=16'hA500
  - a CFG_CNT=4 constant.
- One natural sub-module, int_sync: a 2-flop synchronizer with async active-low reset.
- The FSM and datapath stay in inert_intf_ctrl.

Test Plan:
- Bench setup: SPI_mnrch plus the SPI_iNEMO1 model, INIT_TMR_W=8.
- Reset released -> wrt=0 for 256 clk, then four wrt pulses with wt_data 0x0D02, 0x1053, 0x1150, 0x1460. Afterwards the model's registers[13]==8'h02 and init_done=1.
- First INT from the model -> exactly two reads (0xA200 then 0xA300). vld pulses once, one clk after the second done, with ptch==16'h5663.
- Second INT -> vld pulse with ptch==16'hCD0D. ptch holds 16'h5663 until that pulse.
- rst_n pulsed low during the RD_H transaction -> ptch/vld/wrt/init_done are 0 immediately. After release, the full PWRUP + config sequence repeats.
- Protocol monitor across all tests: wrt is never asserted between a wrt and its done, and wrt is always exactly 1 clk wide.
- ROLL_RD_EN defined -> after INT, four reads in order A2, A3, A4, A5, then a single vld with ptch and roll both updated.
